// File: rtl/lc3b_types.sv
// Shared LC-3b memory types: word/line widths and the responder state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    // A line is 16 bytes, so the line index starts just above the byte offset.
    localparam int LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        RSP_IDLE    = 2'd0,
        RSP_BUSY    = 2'd1,
        RSP_RESP    = 2'd2,
        RSP_RECOVER = 2'd3
    } responder_state_e;

    // Value the latency counter is loaded with on acceptance.
    function automatic logic [3:0] latency_load(input int latency);
        return 4'(latency - 1);
    endfunction

endpackage

// File: rtl/l1_mem_responder_if.sv
// Line-granular memory handshake between the arbitrated L1 side and the responder.
interface l1_mem_responder_if;
    import lc3b_types::*;

    logic     mem_read;
    logic     mem_write;
    lc3b_word mem_address;
    lc3b_line mem_wdata;
    lc3b_line mem_rdata;
    logic     mem_resp;

    // The L1 side issues requests and receives the completion pulse.
    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_wdata,
        input  mem_rdata,
        input  mem_resp
    );

    // The responder consumes requests and produces the completion pulse.
    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_wdata,
        output mem_rdata,
        output mem_resp
    );

endinterface

// File: rtl/l1_mem_responder_line_store.sv
// Line storage: LINES x 128 bits, combinational read, synchronous write.
// Contents are deliberately not reset; a line is undefined until written.
module line_store
    import lc3b_types::*;
#(
    parameter int LINES = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(LINES)-1:0] addr,
    input  lc3b_line                 wdata,
    output lc3b_line                 rdata
);

    lc3b_line lines_q [LINES];

    // Commit a line on the write-enable; no reset so storage survives reset.
    always_ff @(posedge clk) begin
        if (we) begin
            lines_q[addr] <= wdata;
        end
    end

    // Read is purely combinational from the addressed line.
    always_comb begin
        rdata = lines_q[addr];
    end

endmodule

// File: rtl/l1_mem_responder.sv
// Single-outstanding line memory responder with a fixed, parameterised latency.
// Request is latched in IDLE, counted down in BUSY, completed with a one-cycle
// pulse in RESP, and followed by a dead RECOVER cycle so a held request cannot
// immediately retrigger.
module l1_mem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY = 4,
    parameter int LINES   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    l1_mem_responder_if.slave mem
);

    localparam int IDX_W = $clog2(LINES);

    localparam logic [1:0] IDLE    = RSP_IDLE;
    localparam logic [1:0] BUSY    = RSP_BUSY;
    localparam logic [1:0] RESP    = RSP_RESP;
    localparam logic [1:0] RECOVER = RSP_RECOVER;

    localparam logic [3:0] CNT_LOAD = latency_load(LATENCY);

    logic [1:0]       state;
    logic [3:0]       count;
    logic             op_write;
    logic [IDX_W-1:0] line_idx_q;
    lc3b_line         wdata_q;

    logic             store_we;
    lc3b_line         store_rdata;

    // Only the line-index field of the address is ever used, so only it is
    // latched; offset bits and bits above the index alias by construction.

    // Request latch, latency counter and state sequencing.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= 4'd0;
            op_write   <= 1'b0;
            line_idx_q <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem.mem_read || mem.mem_write) begin
                        op_write   <= mem.mem_write;
                        line_idx_q <= mem.mem_address[LINE_OFFSET_BITS +: IDX_W];
                        wdata_q    <= mem.mem_wdata;
                        if (LATENCY == 1) begin
                            count <= 4'd0;
                            state <= RESP;
                        end else begin
                            count <= CNT_LOAD;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= RECOVER;
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A write commits on the edge that leaves RESP, unless reset aborts it.
    always_comb begin
        store_we = (state == RESP) && op_write && reset_n;
    end

    line_store #(
        .LINES (LINES)
    ) u_line_store (
        .clk   (clk),
        .we    (store_we),
        .addr  (line_idx_q),
        .wdata (wdata_q),
        .rdata (store_rdata)
    );

    // Response outputs are only live in RESP; writes echo the latched data.
    always_comb begin
        mem.mem_resp  = 1'b0;
        mem.mem_rdata = '0;
        if (state == RESP) begin
            mem.mem_resp  = 1'b1;
            mem.mem_rdata = op_write ? wdata_q : store_rdata;
        end
    end

endmodule
